alu_issue_queue: RTL and testbench

- Upstream issue stage for pipelined_alu.
- Buffers tagged operation requests in a small FIFO and issues at most one per cycle on the ALU's a/b/op inputs.
- Tracks each issued tag through the ALU's fixed 2-cycle latency, so every returned 16-bit result is paired with its tag and an illegal-op flag.
- Downstream consumers see a clean valid/tag/data result stream. The result side has no backpressure.

---
 rtl/alu_issue_queue.sv | 107 ++++++++++
 tb/tb_alu_issue_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Issue queue in front of pipelined_alu: buffers tagged requests, issues one per cycle,
// and tracks tags through the fixed ALU latency so results come back paired with tag/err.
`timescale 1ns/1ps
module alu_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_a,
    input  logic [7:0]               in_b,
    input  logic [2:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     hold,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic [2:0]               alu_op,
    input  logic [15:0]              alu_result,
    output logic                     res_valid,
    output logic [TAG_W-1:0]         res_tag,
    output logic [15:0]              res_data,
    output logic                     res_err,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [7:0]       a;
        logic [7:0]       b;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t                         r_mem [DEPTH];
    logic [AW-1:0]                r_wr_ptr;
    logic [AW-1:0]                r_rd_ptr;
    logic [AW:0]                  r_count;
    logic [ALU_LAT-1:0]           r_vld_pipe;
    logic [ALU_LAT-1:0]           r_err_pipe;
    logic [ALU_LAT-1:0][TAG_W-1:0] r_tag_pipe;

    logic w_push;
    logic w_pop;
    req_t w_head;

    assign w_head   = r_mem[r_rd_ptr];
    // Full test uses the pre-pop count, so a full queue never accepts in the cycle it pops.
    assign in_ready = reset && (r_count != FULL);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_count != '0) && !hold;

    // Idle cycles present op 111 so the ALU produces zero.
    assign alu_a  = w_pop ? w_head.a  : 8'h00;
    assign alu_b  = w_pop ? w_head.b  : 8'h00;
    assign alu_op = w_pop ? w_head.op : 3'b111;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a, in_b, in_op, in_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag tracker mirrors the ALU pipeline depth; clearing it on reset kills in-flight results.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld_pipe <= '0;
            r_tag_pipe <= '0;
            r_err_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= w_pop;
            r_tag_pipe[0] <= w_pop ? w_head.tag : '0;
            r_err_pipe[0] <= w_pop && (w_head.op >= 3'b110);
            for (int i = 1; i < ALU_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_tag_pipe[i] <= r_tag_pipe[i-1];
                r_err_pipe[i] <= r_err_pipe[i-1];
            end
        end
    end

    assign res_valid = r_vld_pipe[ALU_LAT-1];
    assign res_tag   = res_valid ? r_tag_pipe[ALU_LAT-1] : '0;
    assign res_err   = res_valid && r_err_pipe[ALU_LAT-1];
    assign res_data  = res_valid ? alu_result : 16'h0000;
    assign count     = r_count;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: includes a 2-stage ALU model, directed stimulus, and a
// scoreboard queue drained by an independent result monitor.
`timescale 1ns/1ps
module tb_alu_issue_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [2:0]  in_op = '0;
    logic [3:0]  in_tag = '0;
    logic        hold = 1'b0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic        res_valid;
    logic [3:0]  res_tag;
    logic [15:0] res_data;
    logic        res_err;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  tag;
        logic [15:0] data;
        logic        err;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, AND_ = 3'd3, OR_ = 3'd4, XOR_ = 3'd5;

    alu_issue_queue #(.DEPTH(4), .TAG_W(4), .ALU_LAT(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag), .hold(hold),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
        .res_err(res_err), .count(count)
    );

    always #5 clk = ~clk;

    // Stand-in for pipelined_alu: two registered stages from operand sample to result.
    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return {8'h00, a} + {8'h00, b};
            3'd1:    return {8'h00, a} - {8'h00, b};
            3'd2:    return 16'(a) * 16'(b);
            3'd3:    return {8'h00, a & b};
            3'd4:    return {8'h00, a | b};
            3'd5:    return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    logic [15:0] alu_s1 = '0;
    logic [15:0] alu_s2 = '0;
    always @(posedge clk) begin
        alu_s1 <= alu_f(alu_a, alu_b, alu_op);
        alu_s2 <= alu_s1;
    end
    assign alu_result = alu_s2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [3:0] tag, input logic [15:0] d, input logic err, input bit expect_it);
        in_valid = 1'b1;
        in_a = a; in_b = b; in_op = op; in_tag = tag;
        if (expect_it) exp_q.push_back('{tag: tag, data: d, err: err});
        tick();
    endtask

    // Monitor: every valid result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got tag %0d data %0h, expected none", res_tag, res_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("res_tag", 32'(res_tag), 32'(mon_e.tag));
                    chk("res_data", 32'(res_data), 32'(mon_e.data));
                    chk("res_err", 32'(res_err), 32'(mon_e.err));
                end
            end else begin
                chk("idle_res_data", 32'(res_data), 32'h0);
                chk("idle_res_tag", 32'(res_tag), 32'h0);
                chk("idle_res_err", 32'(res_err), 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        tick(); tick();
        @(negedge clk); chk("in_ready_in_reset", 32'(in_ready), 32'h0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_alu_op", 32'(alu_op), 32'h7);
        tick();

        // Single ADD: issued the cycle after accept, result two cycles later
        put(8'd200, 8'd100, ADD, 4'd3, 16'd300, 1'b0, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_alu_a", 32'(alu_a), 32'd200);
        chk("t1_alu_b", 32'(alu_b), 32'd100);
        chk("t1_alu_op", 32'(alu_op), 32'(ADD));
        tick(); @(negedge clk); chk("t1_valid_early", 32'(res_valid), 32'h0);
        tick(); @(negedge clk); chk("t1_valid_lat2", 32'(res_valid), 32'h1);
        repeat (3) tick();

        // Back-to-back MUL / SUB / XOR
        put(8'hFF, 8'hFF, MUL,  4'd1, 16'hFE01, 1'b0, 1'b1);
        put(8'd5,  8'd7,  SUB,  4'd2, 16'hFFFE, 1'b0, 1'b1);
        put(8'hF0, 8'h0F, XOR_, 4'd4, 16'h00FF, 1'b0, 1'b1);
        in_valid = 1'b0;
        @(negedge clk); chk("t2_valid0", 32'(res_valid), 32'h1);
        tick(); @(negedge clk); chk("t2_valid1", 32'(res_valid), 32'h1);
        tick(); @(negedge clk); chk("t2_valid2", 32'(res_valid), 32'h1);
        tick(); @(negedge clk); chk("t2_valid_end", 32'(res_valid), 32'h0);
        repeat (3) tick();

        // Hold: fill to DEPTH, fifth request ignored, then drain in order
        hold = 1'b1;
        put(8'd1,  8'd2,  ADD,  4'd8,  16'h0003, 1'b0, 1'b1);
        put(8'hFF, 8'h3C, AND_, 4'd9,  16'h003C, 1'b0, 1'b1);
        put(8'h0F, 8'hF0, OR_,  4'd10, 16'h00FF, 1'b0, 1'b1);
        put(8'd16, 8'd16, MUL,  4'd11, 16'h0100, 1'b0, 1'b1);
        @(negedge clk);
        chk("t3_in_ready_full", 32'(in_ready), 32'h0);
        chk("t3_count_full", 32'(count), 32'd4);
        chk("t3_alu_op_hold", 32'(alu_op), 32'h7);
        chk("t3_no_valid", 32'(res_valid), 32'h0);
        put(8'd9, 8'd9, ADD, 4'd12, 16'd18, 1'b0, 1'b0);
        in_valid = 1'b0;
        hold = 1'b0;
        @(negedge clk);
        chk("t3_count_after_ignored", 32'(count), 32'd4);
        chk("t3_in_ready_still_full", 32'(in_ready), 32'h0);
        chk("t3_head_a", 32'(alu_a), 32'd1);
        tick(); @(negedge clk);
        chk("t3_count_3", 32'(count), 32'd3);
        chk("t3_in_ready_back", 32'(in_ready), 32'h1);
        repeat (7) tick();
        chk("t3_drained", 32'(count), 32'd0);

        // Full with hold released and in_valid held high: steady push+pop
        hold = 1'b1;
        for (int i = 0; i < 4; i++)
            put(8'h10 + 8'(i), 8'h20, ADD, 4'(i), 16'h0030 + 16'(i), 1'b0, 1'b1);
        hold = 1'b0;
        in_a = 8'h14; in_b = 8'h20; in_op = ADD; in_tag = 4'd4;
        exp_q.push_back('{tag: 4'd4, data: 16'h0034, err: 1'b0});
        @(negedge clk);
        chk("t4_in_ready_full", 32'(in_ready), 32'h0);
        chk("t4_count_full", 32'(count), 32'd4);
        chk("t4_head_a", 32'(alu_a), 32'h10);
        tick(); @(negedge clk);
        chk("t4_in_ready_reopen", 32'(in_ready), 32'h1);
        chk("t4_count_3", 32'(count), 32'd3);
        tick();
        for (int i = 5; i < 8; i++) begin
            in_a = 8'h10 + 8'(i); in_b = 8'h20; in_op = ADD; in_tag = 4'(i);
            exp_q.push_back('{tag: 4'(i), data: 16'h0030 + 16'(i), err: 1'b0});
            @(negedge clk);
            chk("t4_count_steady", 32'(count), 32'd3);
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        chk("t4_drained", 32'(count), 32'd0);

        // Illegal opcode
        put(8'd3, 8'd4, 3'b110, 4'd9, 16'h0000, 1'b1, 1'b1);
        in_valid = 1'b0;
        repeat (4) tick();

        // Reset mid-operation: tag 5 in flight, 6 and 7 queued
        hold = 1'b1;
        put(8'h55, 8'h0F, XOR_, 4'd5, 16'h005A, 1'b0, 1'b1);
        put(8'd1,  8'd1,  ADD,  4'd6, 16'h0002, 1'b0, 1'b1);
        put(8'd2,  8'd2,  ADD,  4'd7, 16'h0004, 1'b0, 1'b1);
        in_valid = 1'b0;
        hold = 1'b0;
        @(negedge clk); chk("t6_issue_tag5_a", 32'(alu_a), 32'h55);
        tick();
        reset = 1'b0;
        hold = 1'b1;
        exp_q.delete();
        @(negedge clk); chk("t6_in_ready_in_reset", 32'(in_ready), 32'h0);
        tick();
        reset = 1'b1;
        hold = 1'b0;
        @(negedge clk);
        chk("t6_count_cleared", 32'(count), 32'h0);
        chk("t6_in_ready_after", 32'(in_ready), 32'h1);
        chk("t6_no_tag5", 32'(res_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(); @(negedge clk);
            chk("t6_no_valid", 32'(res_valid), 32'h0);
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
